lns_to_fixed: RTL and testbench

//  Sequential decoder from the 16-bit LNS word (base 2^(1/512)) back to signed fixed point; inverse of the LNS encoding used by the adder datapath.

---
 rtl/lns_to_fixed.sv | 206 ++++++++++++++++++++
 tb/tb_lns_to_fixed.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lns_to_fixed.sv
`default_nettype none
// ============================================================================
//  Module      : lns_to_fixed
//  Description : Sequential decoder from a 16-bit logarithmic-number-system
//                word (base 2^(1/512)) to signed two's-complement fixed point.
//                The fractional part of the log is resolved one bit per cycle
//                by multiplying a Q1.17 mantissa with a table of 2^(2^-k)
//                roots. The integer part is then applied as a shift, with
//                saturation.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      clock, rising edge
//    reset      in   1      asynchronous, active-high
//    in_valid   in   1      lns_in valid
//    in_ready   out  1      decoder idle, can accept a word
//    lns_in     in   16     [15]=sign, [14:0]=two's-comp log (9 frac bits)
//                           16'h4000 encodes zero
//    out_valid  out  1      fx_out valid, held until accepted
//    out_ready  in   1      consumer accepts fx_out
//    fx_out     out  OUT_W  signed fixed point, OUT_FRAC fraction bits
//    sat        out  1      fx_out was saturated; qualified by out_valid
// ============================================================================
module lns_to_fixed #(
    parameter int OUT_W    = 32,
    parameter int OUT_FRAC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      lns_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] fx_out,
    output logic             sat
);

    localparam logic [15:0]      C_ZERO_CODE  = 16'h4000;
    localparam logic [17:0]      C_M_ONE      = 18'd131072;     // 1.0 in Q1.17
    localparam logic [3:0]       C_LAST_ITER  = 4'd9;
    // Output weight of mantissa LSB relative to the log integer part:
    // value = m * 2^(I + OUT_FRAC - 17) in output LSBs.
    localparam int               C_SHIFT_BIAS = OUT_FRAC - 17;
    // Smallest integer exponent whose value no longer fits the output.
    localparam int               C_SAT_EXP    = OUT_W - 1 - OUT_FRAC;
    localparam logic [OUT_W-1:0] C_MAX_POS    = {1'b0, {(OUT_W-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [3:0]        r_k;          // iteration index, 1..9 while in ST_ITER
    logic [17:0]       r_m;          // Q1.17 mantissa, stays in [1.0, 2.0)
    logic [8:0]        r_frac;       // remaining fraction bits, MSB consumed first
    logic signed [5:0] r_exp;        // integer part of the log
    logic              r_sign;
    logic              r_zero;
    logic              r_out_valid;
    logic              r_sat;
    logic [OUT_W-1:0]  r_fx;

    logic [17:0]       w_root;
    logic [35:0]       w_prod;
    logic [17:0]       w_m_next;
    logic [17:0]       w_unused_prod_bits;

    int                w_shift;
    logic [OUT_W-1:0]  w_m_ext;
    logic [OUT_W-1:0]  w_mag;
    logic [OUT_W-1:0]  w_fx;
    logic              w_sat;

    // ------------------------------------------------------------------------
    // Root table: round(2^(2^-k) * 2^17)
    // ------------------------------------------------------------------------
    always_comb begin
        w_root = C_M_ONE;
        case (r_k)
            4'd1:    w_root = 18'd185364;
            4'd2:    w_root = 18'd155872;
            4'd3:    w_root = 18'd142935;
            4'd4:    w_root = 18'd136875;
            4'd5:    w_root = 18'd133942;
            4'd6:    w_root = 18'd132499;
            4'd7:    w_root = 18'd131784;
            4'd8:    w_root = 18'd131427;
            4'd9:    w_root = 18'd131250;
            default: w_root = C_M_ONE;
        endcase
    end

    // 18x18 unsigned product rescaled to Q1.17 by truncation. Both factors
    // are below 2.0 and the running product stays below 2.0, so bit 35 is
    // always zero and bits [16:0] are dropped.
    assign w_prod             = 36'(r_m) * 36'(w_root);
    assign w_m_next           = w_prod[34:17];
    assign w_unused_prod_bits = {w_prod[35], w_prod[16:0]};

    // ------------------------------------------------------------------------
    // Final scaling by the integer exponent, saturation and sign
    // ------------------------------------------------------------------------
    always_comb begin
        w_shift = int'(r_exp) + C_SHIFT_BIAS;
        w_m_ext = OUT_W'(r_m);
        w_mag   = '0;
        w_sat   = 1'b0;
        w_fx    = '0;

        if (int'(r_exp) >= C_SAT_EXP) begin
            w_mag = C_MAX_POS;
            w_sat = 1'b1;
        end else if (w_shift >= 0) begin
            w_mag = w_m_ext << w_shift;
        end else begin
            // Large right shifts underflow cleanly to zero without flagging.
            w_mag = w_m_ext >> (-w_shift);
        end

        // Magnitude never exceeds 2^(OUT_W-1)-1, so negation cannot overflow.
        w_fx = r_sign ? (~w_mag + 1'b1) : w_mag;

        if (r_zero) begin
            w_fx  = '0;
            w_sat = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_k         <= 4'd0;
            r_m         <= C_M_ONE;
            r_frac      <= 9'd0;
            r_exp       <= 6'sd0;
            r_sign      <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
            r_fx        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign  <= lns_in[15];
                        r_exp   <= $signed(lns_in[14:9]);
                        r_frac  <= lns_in[8:0];
                        r_zero  <= (lns_in == C_ZERO_CODE);
                        r_m     <= C_M_ONE;
                        r_k     <= 4'd1;
                        r_state <= ST_ITER;
                    end
                end

                ST_ITER: begin
                    // Fixed nine-cycle walk regardless of the fraction value.
                    if (r_frac[8]) begin
                        r_m <= w_m_next;
                    end
                    r_frac <= r_frac << 1;
                    if (r_k == C_LAST_ITER) begin
                        r_state <= ST_SCALE;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end

                ST_SCALE: begin
                    r_fx        <= w_fx;
                    r_sat       <= w_sat;
                    r_out_valid <= 1'b1;
                    r_k         <= 4'd0;
                    r_state     <= ST_DONE;
                end

                ST_DONE: begin
                    // Result is held until the consumer takes it; a new word
                    // can only be accepted from the following cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Gated by reset so the upstream never sees ready during reset.
    assign in_ready  = (r_state == ST_IDLE) && !reset;
    assign out_valid = r_out_valid;
    assign fx_out    = r_fx;
    assign sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_lns_to_fixed.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lns_to_fixed
//  Description : Self-checking bench for lns_to_fixed. Expected results are
//                queued when a word is accepted and compared when the decoder
//                hands its output over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lns_to_fixed;

    localparam int OUT_W    = 32;
    localparam int OUT_FRAC = 16;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      lns_in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] fx_out;
    logic             sat;

    int               checks   = 0;
    int               failures = 0;
    int               cycle    = 0;

    logic [32:0]      exp_q[$];   // {sat, fx_out}
    int               lat_q[$];   // cycle count at the accept edge

    lns_to_fixed #(
        .OUT_W    (OUT_W),
        .OUT_FRAC (OUT_FRAC)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lns_in    (lns_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fx_out    (fx_out),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cycle);
        end
    endtask

    // Reference decoder built from the arithmetic definition of the format.
    function automatic logic [32:0] model(input logic [15:0] w);
        logic signed [5:0] e;
        logic [8:0]        f;
        longint            m;
        longint            r;
        longint            mag;
        logic [31:0]       fx;
        logic              s;
        if (w == 16'h4000) return 33'd0;
        e = w[14:9];
        f = w[8:0];
        m = 131072;
        for (int k = 1; k <= 9; k++) begin
            if (f[9-k]) begin
                r = longint'($rtoi($pow(2.0, 1.0 / real'(1 << k)) * 131072.0 + 0.5));
                m = (m * r) >> 17;
            end
        end
        s = 1'b0;
        if (int'(e) >= 15) begin
            mag = 64'h7FFF_FFFF;
            s   = 1'b1;
        end else if (int'(e) >= 1) begin
            mag = m << (int'(e) - 1);
        end else begin
            mag = m >> (1 - int'(e));
        end
        fx = 32'(mag);
        if (w[15]) fx = -fx;
        return {s, fx};
    endfunction

    // Drive one word once the decoder is ready; caller sits at posedge+1.
    task automatic send(input logic [15:0] w, input logic [32:0] want);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check_value("ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        lns_in   = w;
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        lat_q.push_back(cycle);
        in_valid = 1'b0;
        lns_in   = 16'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: latency, hold stability and scoreboard comparison.
    initial begin
        logic              seen;
        logic [OUT_W-1:0]  held_fx;
        logic              held_sat;
        logic [32:0]       want;
        seen = 1'b0;
        held_fx = '0;
        held_sat = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen     = 1'b1;
                    held_fx  = fx_out;
                    held_sat = sat;
                    if (lat_q.size() == 0) begin
                        check_value("spurious_out_valid", 64'd1, 64'd0);
                    end else begin
                        check_value("latency", 64'(cycle - lat_q.pop_front()), 64'd10);
                    end
                end else begin
                    check_value("hold_fx", 64'(fx_out), 64'(held_fx));
                    check_value("hold_sat", 64'(sat), 64'(held_sat));
                end
                check_value("in_ready_busy", 64'(in_ready), 64'd0);
                if (out_ready) begin
                    seen = 1'b0;
                    if (exp_q.size() != 0) begin
                        want = exp_q.pop_front();
                        check_value("fx_out", 64'(fx_out), 64'(want[31:0]));
                        check_value("sat", 64'(sat), 64'(want[32]));
                    end
                end
            end
        end
    end

    logic [15:0] vec_w [0:8];
    logic [32:0] vec_e [0:8];

    initial begin
        logic [15:0] w;
        int          n;

        vec_w = '{16'h0000, 16'h0200, 16'h7E00, 16'h8200, 16'h0100,
                  16'h4000, 16'h1E00, 16'h5E00, 16'h9E00};
        vec_e = '{{1'b0, 32'h0001_0000}, {1'b0, 32'h0002_0000}, {1'b0, 32'h0000_8000},
                  {1'b0, 32'hFFFE_0000}, {1'b0, 32'h0001_6A0A}, {1'b0, 32'h0000_0000},
                  {1'b1, 32'h7FFF_FFFF}, {1'b0, 32'h0000_0000}, {1'b1, 32'h8000_0001}};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        lns_in    = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        check_value("rst_out_valid", 64'(out_valid), 64'd0);
        check_value("rst_fx_out", 64'(fx_out), 64'd0);
        check_value("rst_sat", 64'(sat), 64'd0);
        check_value("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check_value("idle_in_ready", 64'(in_ready), 64'd1);
        wait_cycles(1);

        // Directed vectors with hand-derived results.
        for (int i = 0; i < 9; i++) begin
            send(vec_w[i], vec_e[i]);
        end

        // Every fraction bit set exercises the full root table.
        send(16'h01FF, model(16'h01FF));
        send(16'h81FF, model(16'h81FF));
        send(16'h1DFF, model(16'h1DFF));

        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            send(w, model(w));
        end

        // Back-pressure: output held 5 cycles, input pulses must be ignored.
        n = 0;
        while (in_ready == 1'b0 && n < 200) begin
            wait_cycles(1);
            n++;
        end
        out_ready = 1'b0;
        send(16'h0100, {1'b0, 32'h0001_6A0A});
        n = 0;
        while (!out_valid && n < 50) begin
            wait_cycles(1);
            n++;
        end
        check_value("stall_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            lns_in   = 16'h0200;
            wait_cycles(1);
            check_value("stall_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(16'h0200, {1'b0, 32'h0002_0000});

        // Reset during the fourth iteration cycle discards the word.
        send(16'h0100, {1'b0, 32'h0001_6A0A});
        wait_cycles(3);
        reset = 1'b1;
        #1;
        check_value("midrst_out_valid", 64'(out_valid), 64'd0);
        check_value("midrst_fx_out", 64'(fx_out), 64'd0);
        check_value("midrst_in_ready", 64'(in_ready), 64'd0);
        void'(exp_q.pop_back());
        void'(lat_q.pop_back());
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(15);
        check_value("midrst_no_output", 64'(out_valid), 64'd0);
        send(16'h7E00, {1'b0, 32'h0000_8000});
        send(16'h8100, {1'b0, 32'hFFFE_95F6});

        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            wait_cycles(1);
            n++;
        end
        check_value("drain", 64'(exp_q.size()), 64'd0);
        wait_cycles(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
